seq_run_ctrl: RTL and testbench
===============================

# seq_run_ctrl

Word-level controller that sequences a serial run detector (one-hot FSM flagging RUN_LEN consecutive equal bits) over parallel input words. The controller accepts a word on a valid/ready handshake, shifts it into the detector one bit per clock, counts detections, and returns a per-word result on a second valid/ready handshake. It sits between a parallel producer (switch/bus register) and a status consumer (LED/readout), replacing hand-clocked single-bit stimulus.

## Interface
- WORD_W, 8, bits per input word (2..16)
- RUN_LEN, 4, run length that raises z (2..8)
- CNT_W, 4, width of per-word match counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  controller can accept a word
- in_word  in  WORD_W  word to scan
- in_clr_hist  in  1  sampled with word; 1 = clear detector run history before scanning
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_count  out  CNT_W  detections in the word, saturating
- out_last_z  out  1  detector z after the word's last bit
- z  out  1  live detector output
- state_oh  out  3  controller state, one-hot

## Operation
- Controller FSM, one-hot: IDLE=001, SHIFT=010, REPORT=100.
- IDLE: in_ready=1. On in_valid&in_ready edge: load shift register with in_word; bit_cnt=0; match_cnt=0; if in_clr_hist, detector run_len=0; go SHIFT.
- SHIFT: one bit per edge, MSB first, fed as w to detector. After WORD_W bits go REPORT. in_valid ignored.
- REPORT: out_valid=1, out_count/out_last_z held stable. On out_valid&out_ready edge go IDLE.
- Detector: holds last bit value and run_len (0..RUN_LEN, saturating). On bit w: if run_len==0 or w!=last, run_len=1; else run_len=min(run_len+1, RUN_LEN). last=w. z=(run_len==RUN_LEN).
- Detection counted on every SHIFT edge where updated z=1; overlapping runs count each bit (run of 6 ones with RUN_LEN=4 → 3).
- match_cnt saturates at 2^CNT_W-1, no wrap.
- History persists across words unless in_clr_hist=1; runs may span word boundaries.
- Reset values: state_oh=001, in_ready=0 while rst low, out_valid=0, out_count=0, out_last_z=0, z=0, run_len=0.

## Timing
- Accept edge E0; bit i consumed at edge E0+1+i; state REPORT and out_valid=1 after edge E0+WORD_W.
- Result latency WORD_W cycles from accept edge; minimum per-word period WORD_W+2 cycles (accept, WORD_W shifts, report handshake with out_ready=1).
- in_ready combinational from IDLE; rises the cycle after report handshake edge.
- z updates on each SHIFT edge; held in IDLE/REPORT.
- rst low at any point (mid-SHIFT, mid-REPORT): all state and outputs to reset values immediately; partial word discarded, no result produced.
- out_ready high while not REPORT: ignored.

## Configuration
- SEQ_RUN_CTRL_LSB_FIRST_EN defined: shift order LSB first (bit 0 consumed at E0+1).
- Undefined: MSB first (bit WORD_W-1 consumed at E0+1). No other behaviour change.

## Test plan
- Defaults, reset, in_word=8'hF0, clr=1, out_ready=1 → out_valid 8 cycles after accept, out_count=2, out_last_z=1, state_oh 001→010→100→001.
- in_word=8'hAA, clr=1 → out_count=0, out_last_z=0, z never high.
- 8'h0F clr=1 (count 2), then 8'hFF clr=0 → out_count=8; repeat 8'hFF with clr=1 after 8'h0F → out_count=5.
- CNT_W=2, in_word=8'h00, clr=1 → out_count=3 (saturated from 5).
- out_ready=0 for 5 cycles in REPORT → out_valid stays 1, out_count stable, in_ready=0, in_valid pulses ignored; accept proceeds after release.
- rst low at 4th SHIFT cycle → outputs zero same cycle, state_oh=001; after release, next word 8'hF0 yields out_count=2.

Source files
------------

// File: rtl/seq_run_ctrl_if.sv
// Word/result handshake bundle for seq_run_ctrl.
//   in_valid/in_ready/in_word/in_clr_hist : word request from the producer
//   out_valid/out_ready/out_count/out_last_z : per-word result to the consumer
//   z, state_oh : live detector output and one-hot controller state
// master = producer/consumer side, slave = controller side.
interface seq_run_ctrl_if #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_word;
  logic              in_clr_hist;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic              out_last_z;
  logic              z;
  logic [2:0]        state_oh;

  modport master (
    output in_valid, in_word, in_clr_hist, out_ready,
    input  in_ready, out_valid, out_count, out_last_z, z, state_oh
  );

  modport slave (
    input  in_valid, in_word, in_clr_hist, out_ready,
    output in_ready, out_valid, out_count, out_last_z, z, state_oh
  );
endinterface

// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: accepts a parallel word, feeds it one bit per clock into a
// run detector (z=1 once RUN_LEN equal bits have been seen in a row), counts
// detections and returns a per-word result on a valid/ready handshake.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : seq_run_ctrl_if.slave (word handshake, result handshake, z, state_oh)
// Option: define SEQ_RUN_CTRL_LSB_FIRST_EN to scan words LSB first
// (default scans MSB first).
module seq_run_ctrl #(
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned RUN_LEN = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_run_ctrl_if.slave  bus
);

  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned RL_W  = $clog2(RUN_LEN + 1);

  localparam logic [2:0] S_IDLE   = 3'b001;
  localparam logic [2:0] S_SHIFT  = 3'b010;
  localparam logic [2:0] S_REPORT = 3'b100;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [RL_W-1:0]  RL_MAX   = RL_W'(RUN_LEN);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);

  logic [2:0]        state_q,     state_d;
  logic [WORD_W-1:0] sh_q,        sh_d;
  logic [BIT_W-1:0]  bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic              last_z_q,    last_z_d;
  logic              last_bit_q,  last_bit_d;
  logic [RL_W-1:0]   run_len_q,   run_len_d;
  logic              z_q,         z_d;

  logic              w_bit;
  logic [WORD_W-1:0] sh_next;
  logic [RL_W-1:0]   run_next;
  logic              hit;

  // Bit presented to the detector this cycle and the shifted remainder
`ifdef SEQ_RUN_CTRL_LSB_FIRST_EN
  assign w_bit   = sh_q[0];
  assign sh_next = sh_q >> 1;
`else
  assign w_bit   = sh_q[WORD_W-1];
  assign sh_next = sh_q << 1;
`endif

  // Detector run length after consuming w_bit (saturates at RUN_LEN)
  always_comb begin
    run_next = run_len_q;
    if ((run_len_q == '0) || (w_bit != last_bit_q)) begin
      run_next = RL_W'(1);
    end else if (run_len_q != RL_MAX) begin
      run_next = run_len_q + RL_W'(1);
    end
  end

  assign hit = (run_next == RL_MAX);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      last_z_q    <= 1'b0;
      last_bit_q  <= 1'b0;
      run_len_q   <= '0;
      z_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      last_z_q    <= last_z_d;
      last_bit_q  <= last_bit_d;
      run_len_q   <= run_len_d;
      z_q         <= z_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    last_z_d    = last_z_q;
    last_bit_d  = last_bit_q;
    run_len_d   = run_len_q;
    z_d         = z_q;

    case (state_q)
      S_IDLE: begin
        // in_ready is high whenever IDLE and out of reset
        if (bus.in_valid) begin
          sh_d        = bus.in_word;
          bit_cnt_d   = '0;
          match_cnt_d = '0;
          if (bus.in_clr_hist) begin
            run_len_d = '0;
            z_d       = 1'b0;
          end
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sh_d       = sh_next;
        last_bit_d = w_bit;
        run_len_d  = run_next;
        z_d        = hit;
        if (hit && (match_cnt_q != CNT_MAX)) begin
          match_cnt_d = match_cnt_q + CNT_W'(1);
        end
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == BIT_LAST) begin
          last_z_d = hit;
          state_d  = S_REPORT;
        end
      end

      S_REPORT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Gated with rst so the producer never sees ready during reset
  assign bus.in_ready   = (state_q == S_IDLE) & rst;
  assign bus.out_valid  = (state_q == S_REPORT);
  assign bus.out_count  = match_cnt_q;
  assign bus.out_last_z = last_z_q;
  assign bus.z          = z_q;
  assign bus.state_oh   = state_q;

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Testbench for seq_run_ctrl (WORD_W=8, RUN_LEN=4; CNT_W=4 main DUT,
// CNT_W=2 second DUT for counter saturation).
module tb_seq_run_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_run_ctrl_if #(.WORD_W(8), .CNT_W(4)) bus ();
  seq_run_ctrl_if #(.WORD_W(8), .CNT_W(2)) bus2 ();

  seq_run_ctrl #(.WORD_W(8), .RUN_LEN(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  seq_run_ctrl #(.WORD_W(8), .RUN_LEN(4), .CNT_W(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2.slave)
  );

  typedef struct packed {
    logic [3:0] cnt;
    logic       lz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc_ctr = 0;

  // Reference model history
  logic m_last = 1'b0;
  int   m_run  = 0;

  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model of one word through the detector
  task automatic model_word(input logic [7:0] w, input logic clr, output exp_t e);
    int   c;
    logic x;
    c = 0;
    if (clr) m_run = 0;
    for (int k = 0; k < 8; k++) begin
`ifdef SEQ_RUN_CTRL_LSB_FIRST_EN
      x = w[k];
`else
      x = w[7-k];
`endif
      if (m_run == 0 || x != m_last) m_run = 1;
      else if (m_run < 4) m_run = m_run + 1;
      m_last = x;
      if (m_run == 4 && c < 15) c = c + 1;
    end
    e.cnt = 4'(c);
    e.lz  = (m_run == 4);
  endtask

  // Present a word and wait (bounded) for the accept edge; returns at the
  // negedge after the accept edge with acc_cyc = cycle count at that point
  task automatic accept_word(input logic [7:0] w, input logic clr,
                             output bit to, output int acc_cyc);
    to = 1'b1;
    acc_cyc = 0;
    bus.in_valid    = 1'b1;
    bus.in_word     = w;
    bus.in_clr_hist = clr;
    for (int i = 0; i < 50; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk);
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    acc_cyc = cyc_ctr;
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid and capture the result; no handshake
  task automatic wait_valid(output logic [3:0] cnt, output logic lz,
                            output logic [2:0] st, output int cyc,
                            output bit zseen, output bit to);
    to = 1'b1; zseen = 1'b0; cyc = 0; cnt = '0; lz = 1'b0; st = '0;
    for (int i = 0; i < 40; i++) begin
      if (bus.z === 1'b1) zseen = 1'b1;
      if (bus.out_valid === 1'b1) begin
        cnt = bus.out_count;
        lz  = bus.out_last_z;
        st  = bus.state_oh;
        cyc = i;
        to  = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_word = '0; bus.in_clr_hist = 1'b0; bus.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_word = '0; bus2.in_clr_hist = 1'b0; bus2.out_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.state_oh !== 3'b001) begin n_err++; $display("FAIL reset_state: got %b want 001", bus.state_oh); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_count !== 4'd0) begin n_err++; $display("FAIL reset_out_count: got %0d want 0", bus.out_count); end
    n_cmp++; if (bus.out_last_z !== 1'b0) begin n_err++; $display("FAIL reset_out_last_z: got %b want 0", bus.out_last_z); end
    n_cmp++; if (bus.z !== 1'b0) begin n_err++; $display("FAIL reset_z: got %b want 0", bus.z); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_f0();
    bit to; int acc; logic [3:0] cnt; logic lz; logic [2:0] st; int cyc; bit zs; exp_t e;
    bus.out_ready = 1'b1;
    sb.push_back('{cnt: 4'd2, lz: 1'b1});
    accept_word(8'hF0, 1'b1, to, acc);
    n_cmp++; if (to) begin n_err++; $display("FAIL f0_accept: got timeout want accept"); end
    n_cmp++; if (bus.state_oh !== 3'b010) begin n_err++; $display("FAIL f0_state_shift: got %b want 010", bus.state_oh); end
    wait_valid(cnt, lz, st, cyc, zs, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL f0_result: got timeout want out_valid"); end
    n_cmp++; if (cyc !== 8) begin n_err++; $display("FAIL f0_latency: got %0d want 8", cyc); end
    n_cmp++; if (st !== 3'b100) begin n_err++; $display("FAIL f0_state_report: got %b want 100", st); end
    n_cmp++; if (cnt !== e.cnt) begin n_err++; $display("FAIL f0_count: got %0d want %0d", cnt, e.cnt); end
    n_cmp++; if (lz !== e.lz) begin n_err++; $display("FAIL f0_last_z: got %b want %b", lz, e.lz); end
    handshake();
    n_cmp++; if (bus.state_oh !== 3'b001) begin n_err++; $display("FAIL f0_state_idle: got %b want 001", bus.state_oh); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL f0_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_alternating();
    bit to; int acc; logic [3:0] cnt; logic lz; logic [2:0] st; int cyc; bit zs; exp_t e;
    sb.push_back('{cnt: 4'd0, lz: 1'b0});
    accept_word(8'hAA, 1'b1, to, acc);
    wait_valid(cnt, lz, st, cyc, zs, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL aa_result: got timeout want out_valid"); end
    n_cmp++; if (cnt !== e.cnt) begin n_err++; $display("FAIL aa_count: got %0d want %0d", cnt, e.cnt); end
    n_cmp++; if (lz !== e.lz) begin n_err++; $display("FAIL aa_last_z: got %b want %b", lz, e.lz); end
    n_cmp++; if (zs !== 1'b0) begin n_err++; $display("FAIL aa_z_seen: got %b want 0", zs); end
    handshake();
  endtask

  // Run history across words, with and without clearing
  task automatic test_history();
    logic [7:0] words [4] = '{8'h0F, 8'hFF, 8'h0F, 8'hFF};
    logic       clrs  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] cnts  [4] = '{4'd2, 4'd8, 4'd2, 4'd5};
    bit to; int acc; logic [3:0] cnt; logic lz; logic [2:0] st; int cyc; bit zs; exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{cnt: cnts[i], lz: 1'b1});
      accept_word(words[i], clrs[i], to, acc);
      wait_valid(cnt, lz, st, cyc, zs, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL hist%0d_result: got timeout want out_valid", i); end
      n_cmp++; if (cnt !== e.cnt) begin n_err++; $display("FAIL hist%0d_count: got %0d want %0d", i, cnt, e.cnt); end
      n_cmp++; if (lz !== e.lz) begin n_err++; $display("FAIL hist%0d_last_z: got %b want %b", i, lz, e.lz); end
      handshake();
    end
  endtask

  task automatic test_saturate();
    bit to;
    bus2.out_ready   = 1'b1;
    bus2.in_word     = 8'h00;
    bus2.in_clr_hist = 1'b1;
    n_cmp++; if (bus2.in_ready !== 1'b1) begin n_err++; $display("FAIL sat_in_ready: got %b want 1", bus2.in_ready); end
    bus2.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.in_valid = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus2.out_valid === 1'b1) begin to = 1'b0; break; end
      @(negedge clk);
    end
    n_cmp++; if (to) begin n_err++; $display("FAIL sat_result: got timeout want out_valid"); end
    n_cmp++; if (bus2.out_count !== 2'd3) begin n_err++; $display("FAIL sat_count: got %0d want 3", bus2.out_count); end
    n_cmp++; if (bus2.out_last_z !== 1'b1) begin n_err++; $display("FAIL sat_last_z: got %b want 1", bus2.out_last_z); end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit to; int acc; logic [3:0] cnt; logic lz; logic [2:0] st; int cyc; bit zs; exp_t e;
    sb.push_back('{cnt: 4'd2, lz: 1'b1});
    bus.out_ready = 1'b0;
    accept_word(8'hF0, 1'b1, to, acc);
    wait_valid(cnt, lz, st, cyc, zs, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL bp_result: got timeout want out_valid"); end
    n_cmp++; if (cnt !== e.cnt) begin n_err++; $display("FAIL bp_count: got %0d want %0d", cnt, e.cnt); end
    for (int k = 0; k < 5; k++) begin
      bus.in_valid    = (k % 2 == 0);
      bus.in_word     = 8'h00;
      bus.in_clr_hist = 1'b1;
      @(negedge clk);
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp%0d_out_valid: got %b want 1", k, bus.out_valid); end
      n_cmp++; if (bus.out_count !== 4'd2) begin n_err++; $display("FAIL bp%0d_out_count: got %0d want 2", k, bus.out_count); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp%0d_in_ready: got %b want 0", k, bus.in_ready); end
      n_cmp++; if (bus.state_oh !== 3'b100) begin n_err++; $display("FAIL bp%0d_state: got %b want 100", k, bus.state_oh); end
    end
    bus.in_valid = 1'b0;
    handshake();
    n_cmp++; if (bus.state_oh !== 3'b001) begin n_err++; $display("FAIL bp_release_state: got %b want 001", bus.state_oh); end
    sb.push_back('{cnt: 4'd2, lz: 1'b1});
    accept_word(8'h0F, 1'b1, to, acc);
    wait_valid(cnt, lz, st, cyc, zs, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL bp_next_result: got timeout want out_valid"); end
    n_cmp++; if (cnt !== e.cnt) begin n_err++; $display("FAIL bp_next_count: got %0d want %0d", cnt, e.cnt); end
    handshake();
  endtask

  task automatic test_reset_mid_shift();
    bit to; int acc; logic [3:0] cnt; logic lz; logic [2:0] st; int cyc; bit zs; exp_t e;
    accept_word(8'hF0, 1'b1, to, acc);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.state_oh !== 3'b001) begin n_err++; $display("FAIL rst_mid_state: got %b want 001", bus.state_oh); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_count !== 4'd0) begin n_err++; $display("FAIL rst_mid_out_count: got %0d want 0", bus.out_count); end
    n_cmp++; if (bus.out_last_z !== 1'b0) begin n_err++; $display("FAIL rst_mid_last_z: got %b want 0", bus.out_last_z); end
    n_cmp++; if (bus.z !== 1'b0) begin n_err++; $display("FAIL rst_mid_z: got %b want 0", bus.z); end
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_in_ready: got %b want 0", bus.in_ready); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // History was cleared by reset, so no clear request is needed
    sb.push_back('{cnt: 4'd2, lz: 1'b1});
    accept_word(8'hF0, 1'b0, to, acc);
    wait_valid(cnt, lz, st, cyc, zs, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL rst_next_result: got timeout want out_valid"); end
    n_cmp++; if (cnt !== e.cnt) begin n_err++; $display("FAIL rst_next_count: got %0d want %0d", cnt, e.cnt); end
    n_cmp++; if (lz !== e.lz) begin n_err++; $display("FAIL rst_next_last_z: got %b want %b", lz, e.lz); end
    handshake();
  endtask

  // Random words at full rate; checks model results and WORD_W+2 period
  task automatic test_back_to_back();
    bit to; int acc; int prev_acc; logic [3:0] cnt; logic lz; logic [2:0] st; int cyc; bit zs; exp_t e;
    logic [7:0] w; logic clr;
    bus.out_ready = 1'b1;
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 3))
        0:       w = 8'hFF;
        1:       w = 8'h00;
        default: w = 8'($urandom_range(0, 255));
      endcase
      clr = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      model_word(w, clr, e);
      sb.push_back(e);
      accept_word(w, clr, to, acc);
      if (prev_acc >= 0) begin
        n_cmp++; if (acc - prev_acc !== 10) begin n_err++; $display("FAIL b2b%0d_period: got %0d want 10", i, acc - prev_acc); end
      end
      prev_acc = acc;
      wait_valid(cnt, lz, st, cyc, zs, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL b2b%0d_result: got timeout want out_valid", i); end
      n_cmp++; if (cnt !== e.cnt) begin n_err++; $display("FAIL b2b%0d_count: word %h got %0d want %0d", i, w, cnt, e.cnt); end
      n_cmp++; if (lz !== e.lz) begin n_err++; $display("FAIL b2b%0d_last_z: word %h got %b want %b", i, w, lz, e.lz); end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_f0();
    test_alternating();
    test_history();
    test_saturate();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
